instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetches 32-bit RV32I instructions over a byte-wide memory read port, one byte per transfer.
//  Assembles the 4 bytes little-endian and presents the word plus its PC to decode.
//  Decode feeds the word to immediate_generator and the control decoder.
//  Owns the program counter; execute redirects it on taken branches and JAL/JALR.
// PARAMETERS
//  RESET_ADDRESS  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clock               input   1   single clock, all state updates on posedge
//  reset               input   1   asynchronous, active-high
//  memory_address      output  32  byte address of the current read (pc + byte_index)
//  memory_read_request output  1   high while a byte is wanted
//  memory_read_data    input   8   read byte, sampled when memory_read_valid is high
//  memory_read_valid   input   1   byte present this cycle; ignored unless request is high
//  redirect_valid      input   1   one-cycle pulse: restart fetch at redirect_address
//  redirect_address    input   32  new PC; bits [1:0] forced to 0 internally
//  instruction         output  32  assembled instruction word
//  instruction_pc      output  32  address of instruction
//  instruction_valid   output  1   instruction/instruction_pc valid
//  instruction_ready   input   1   decode accepts the word this cycle
// BEHAVIOUR
//  Reset (async, applied immediately):
//   - state=START, pc=RESET_ADDRESS, byte_index=0.
//   - instruction=0, instruction_pc=RESET_ADDRESS, instruction_valid=0, memory_read_request=0.
//  FSM:
//   - START: request=0; goes to FETCH next cycle.
//   - FETCH: request=1, memory_address=pc+byte_index. On read_valid: store data in instruction[8*byte_index+:8].
//     If byte_index<3, byte_index+1. If byte_index==3, go to HOLD, instruction_valid=1 next cycle.
//   - HOLD: request=0, instruction_valid=1. On valid&ready: pc=pc+4, byte_index=0, go to FETCH.
//     Otherwise hold instruction and instruction_pc stable; valid never drops without acceptance.
//  Address and handshake rules:
//   - memory_address and request are combinational from registered state; stable until read_valid.
//   - instruction_pc equals pc while in HOLD. pc+4 and pc+byte_index wrap modulo 2^32 (0xFFFF_FFFC -> 0).
//  Timing:
//   - Latency: zero-wait memory gives valid 4 cycles after entering FETCH.
//   - Best-case throughput is 1 instruction per 5 cycles (ready high in HOLD).
//  Redirect (highest priority, any state incl. START):
//   - Next cycle: pc={redirect_address[31:2],2'b00}, byte_index=0, state=FETCH, instruction_valid=0.
//   - A read_valid in the redirect cycle is discarded; partial bytes are dropped.
//   - Redirect in the same cycle as a HOLD accept: the accept completes (decode took the word); redirect wins for pc.
//  Misc:
//   - read_valid while request=0 has no effect. No internal timeout.
//   - Reset mid-transfer aborts; the memory side must tolerate a dropped request.
// STRUCTURE
//  - Shared core package additions:
//    - fetch_state_t enum {START, FETCH, HOLD}.
//    - INSTRUCTION_BYTES=4.
//    - NOP_INSTRUCTION=32'h0000_0013.
//  - Single module, no sub-modules. Byte assembly is an indexed register write.
//  - Registers: state, pc, byte_index[1:0], instruction.
// TESTING
//  1. Reset with RESET_ADDRESS=0, memory returns 13 00 00 00 zero-wait, ready=1 ->
//     addresses 0,1,2,3; instruction=0x00000013, pc=0; next fetch at address 4.
//  2. Ready held low 10 cycles in HOLD -> valid, instruction and pc stable and request=0 throughout;
//     ready=1 -> fetch resumes at pc+4.
//  3. Redirect to 0x0000_0102 after 2 bytes received -> next address 0x100;
//     earlier bytes discarded; delivered pc=0x100.
//  4. Random 0-3 wait cycles between read_valid pulses -> address held stable while waiting;
//     word matches memory model.
//  5. pc=0xFFFF_FFFC accepted -> next fetch address 0x0000_0000 (wrap).
//  6. Async reset asserted mid-FETCH between clock edges -> valid=0 and request=0 immediately;
//     restart at RESET_ADDRESS via START.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared core definitions for the byte-serial instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned BYTE_WIDTH        = 8;
    localparam int unsigned INSTRUCTION_BYTES = 4;
    localparam int unsigned BYTE_INDEX_WIDTH  = $clog2(INSTRUCTION_BYTES);

    localparam logic [XLEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Clear the byte-offset bits so the PC always points at a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] address);
        return {address[XLEN-1:BYTE_INDEX_WIDTH], BYTE_INDEX_WIDTH'(0)};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Byte-serial RV32I instruction fetch: assembles four little-endian bytes per
// word, holds the word until decode accepts it, and owns the program counter.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDRESS = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [XLEN-1:0]       memory_address,
    output logic                  memory_read_request,
    input  logic [BYTE_WIDTH-1:0] memory_read_data,
    input  logic                  memory_read_valid,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_address,
    output logic [XLEN-1:0]       instruction,
    output logic [XLEN-1:0]       instruction_pc,
    output logic                  instruction_valid,
    input  logic                  instruction_ready
);

    localparam logic [BYTE_INDEX_WIDTH-1:0] LAST_BYTE = BYTE_INDEX_WIDTH'(INSTRUCTION_BYTES - 1);
    localparam logic [XLEN-1:0]             PC_STEP   = XLEN'(INSTRUCTION_BYTES);

    fetch_state_t                state;
    logic [XLEN-1:0]             pc;
    logic [BYTE_INDEX_WIDTH-1:0] byte_index;

    // Fetch sequencer: redirect overrides everything, bytes land at their lane.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= START;
            pc          <= RESET_ADDRESS;
            byte_index  <= '0;
            instruction <= '0;
        end else if (redirect_valid) begin
            state      <= FETCH;
            pc         <= align_word(redirect_address);
            byte_index <= '0;
        end else begin
            unique case (state)
                START: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (memory_read_valid) begin
                        instruction[{byte_index, 3'b000} +: BYTE_WIDTH] <= memory_read_data;
                        if (byte_index == LAST_BYTE) begin
                            byte_index <= '0;
                            state      <= HOLD;
                        end else begin
                            byte_index <= byte_index + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (instruction_ready) begin
                        pc         <= pc + PC_STEP;
                        byte_index <= '0;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end

    // Memory and decode handshakes are pure decodes of registered state.
    assign memory_read_request = (state == FETCH);
    assign memory_address      = pc + XLEN'(byte_index);
    assign instruction_valid   = (state == HOLD);
    assign instruction_pc      = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed table plus a
// randomized phase scored against a byte-memory model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam logic [31:0] RESET_ADDRESS = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] memory_address;
    logic        memory_read_request;
    logic [7:0]  memory_read_data;
    logic        memory_read_valid;
    logic        redirect_valid;
    logic [31:0] redirect_address;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_valid;
    logic        instruction_ready;

    instruction_fetch_unit #(.RESET_ADDRESS(RESET_ADDRESS)) dut (
        .clock               (clock),
        .reset               (reset),
        .memory_address      (memory_address),
        .memory_read_request (memory_read_request),
        .memory_read_data    (memory_read_data),
        .memory_read_valid   (memory_read_valid),
        .redirect_valid      (redirect_valid),
        .redirect_address    (redirect_address),
        .instruction         (instruction),
        .instruction_pc      (instruction_pc),
        .instruction_valid   (instruction_valid),
        .instruction_ready   (instruction_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] next;
    } vec_t;

    vec_t        vecs [4];
    logic [7:0]  mem_bytes [logic [31:0]];
    logic [31:0] addr_log [$];
    int          checks;
    int          failures;
    int          cyc;
    int          max_wait;
    int          wait_left;
    bit          spurious_on;
    int          first_req;
    int          v1;
    int          v2;
    int          bytes_got;
    logic [31:0] exp_pc;
    logic [31:0] target;
    bit          delivered;
    bit          go_ready;
    bit          go_redirect;
    bit          accept;

    function automatic logic [7:0] mem_read(input logic [31:0] a);
        if (mem_bytes.exists(a)) return mem_bytes[a];
        return 8'(((a ^ 32'h5A5A_0F0F) * 32'h9E37_79B1) >> 24);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_read(a + 32'd3), mem_read(a + 32'd2), mem_read(a + 32'd1), mem_read(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of bench time: memory responder reacts to the current request.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (memory_read_request && !reset) begin
            if (wait_left == 0) begin
                memory_read_valid = 1'b1;
                memory_read_data  = mem_read(memory_address);
                addr_log.push_back(memory_address);
                wait_left = int'($urandom_range(0, max_wait));
            end else begin
                memory_read_valid = 1'b0;
                memory_read_data  = 8'($urandom);
                wait_left--;
            end
        end else begin
            memory_read_valid = spurious_on && ($urandom_range(0, 2) == 0);
            memory_read_data  = 8'($urandom);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!instruction_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(instruction_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0;
        max_wait = 0; wait_left = 0; spurious_on = 1'b0;
        reset = 1'b1;
        memory_read_valid = 1'b0; memory_read_data = 8'h00;
        redirect_valid = 1'b0; redirect_address = 32'h0;
        instruction_ready = 1'b0;
        target = 32'h0;

        vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0104};
        vecs[1] = '{32'h0000_2003, 32'h0000_2000, 32'h0050_0093, 32'h0000_2004};
        vecs[2] = '{32'h8000_0041, 32'h8000_0040, 32'hCAFE_F00D, 32'h8000_0044};
        vecs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0000};
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                mem_bytes[vecs[i].pc + 32'(k)] = vecs[i].word[8*k +: 8];
        mem_bytes[32'h0] = 8'h13;
        mem_bytes[32'h1] = 8'h00;
        mem_bytes[32'h2] = 8'h00;
        mem_bytes[32'h3] = 8'h00;

        // Reset state
        tick();
        tick();
        check("reset_valid", 32'(instruction_valid), 32'd0);
        check("reset_request", 32'(memory_read_request), 32'd0);
        check("reset_instruction", instruction, 32'h0);
        check("reset_pc", instruction_pc, RESET_ADDRESS);
        check("reset_address", memory_address, RESET_ADDRESS);

        // First fetch from reset, zero-wait memory, decode always ready
        reset = 1'b0;
        instruction_ready = 1'b1;
        check("start_no_request", 32'(memory_read_request), 32'd0);
        addr_log.delete();
        first_req = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (memory_read_request && first_req < 0) first_req = cyc;
            if (instruction_valid) break;
        end
        v1 = cyc;
        check("first_valid", 32'(instruction_valid), 32'd1);
        check("first_latency", 32'(v1 - first_req), 32'd4);
        check("first_addr_count", 32'(addr_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
            check("first_addr", addr_log[k], 32'(k));
        check("first_word", instruction, NOP_INSTRUCTION);
        check("first_pc", instruction_pc, 32'h0);
        tick();
        check("next_fetch_request", 32'(memory_read_request), 32'd1);
        check("next_fetch_addr", memory_address, 32'h4);

        // Best-case throughput, then decode stalls in HOLD
        instruction_ready = 1'b0;
        wait_valid("second_valid", 20);
        v2 = cyc;
        check("throughput", 32'(v2 - v1), 32'd5);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_valid", 32'(instruction_valid), 32'd1);
            check("hold_word", instruction, word_at(32'h4));
            check("hold_pc", instruction_pc, 32'h4);
            check("hold_no_request", 32'(memory_read_request), 32'd0);
        end
        instruction_ready = 1'b1;
        tick();
        check("resume_request", 32'(memory_read_request), 32'd1);
        check("resume_addr", memory_address, 32'h8);
        tick();
        tick();
        check("third_byte_addr", memory_address, 32'hA);

        // Redirect table: each redirect lands mid-fetch, partial bytes dropped
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'b1;
            redirect_address = vecs[i].target;
            tick();
            redirect_valid = 1'b0;
            instruction_ready = 1'b0;
            check("tbl_valid_drop", 32'(instruction_valid), 32'd0);
            check("tbl_request", 32'(memory_read_request), 32'd1);
            check("tbl_addr", memory_address, vecs[i].pc);
            wait_valid("tbl_valid", 20);
            check("tbl_word", instruction, vecs[i].word);
            check("tbl_pc", instruction_pc, vecs[i].pc);
            instruction_ready = 1'b1;
            tick();
            instruction_ready = 1'b0;
            check("tbl_next_addr", memory_address, vecs[i].next);
            check("tbl_next_request", 32'(memory_read_request), 32'd1);
            tick();
        end
        wait_valid("wrap_valid", 20);
        check("wrap_word", instruction, NOP_INSTRUCTION);
        check("wrap_pc", instruction_pc, 32'h0);

        // Accept and redirect in the same HOLD cycle
        instruction_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_address = 32'h2000_0006;
        tick();
        instruction_ready = 1'b0;
        redirect_valid = 1'b0;
        check("combo_valid_drop", 32'(instruction_valid), 32'd0);
        check("combo_addr", memory_address, 32'h2000_0004);
        wait_valid("combo_valid", 20);
        check("combo_word", instruction, word_at(32'h2000_0004));
        check("combo_pc", instruction_pc, 32'h2000_0004);

        // Asynchronous reset between clock edges in the middle of a fetch
        instruction_ready = 1'b1;
        tick();
        instruction_ready = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check("async_valid", 32'(instruction_valid), 32'd0);
        check("async_request", 32'(memory_read_request), 32'd0);
        check("async_addr", memory_address, RESET_ADDRESS);
        check("async_pc", instruction_pc, RESET_ADDRESS);
        tick();
        reset = 1'b0;
        check("restart_start_no_request", 32'(memory_read_request), 32'd0);
        tick();
        check("restart_request", 32'(memory_read_request), 32'd1);
        check("restart_addr", memory_address, RESET_ADDRESS);
        wait_valid("restart_valid", 20);
        check("restart_word", instruction, NOP_INSTRUCTION);
        check("restart_pc", instruction_pc, RESET_ADDRESS);

        // Redirect while still in START
        reset = 1'b1;
        tick();
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_address = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check("start_redirect_request", 32'(memory_read_request), 32'd1);
        check("start_redirect_addr", memory_address, 32'h0000_0100);
        wait_valid("start_redirect_valid", 20);
        check("start_redirect_word", instruction, vecs[0].word);
        check("start_redirect_pc", instruction_pc, 32'h0000_0100);

        // Randomized phase: wait states, spurious valids, random ready/redirect
        exp_pc = 32'h0000_0100;
        bytes_got = 4;
        max_wait = 3;
        spurious_on = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            tick();
            check("rnd_valid", 32'(instruction_valid), 32'(bytes_got == 4));
            check("rnd_request", 32'(memory_read_request), 32'(bytes_got != 4));
            if (memory_read_request)
                check("rnd_addr", memory_address, exp_pc + 32'(bytes_got));
            if (instruction_valid) begin
                check("rnd_word", instruction, word_at(exp_pc));
                check("rnd_pc", instruction_pc, exp_pc);
            end
            delivered   = memory_read_valid && memory_read_request;
            go_ready    = ($urandom_range(0, 1) == 1);
            go_redirect = ($urandom_range(0, 39) == 0);
            accept      = instruction_valid && go_ready;
            if (accept) begin
                exp_pc = exp_pc + 32'd4;
                bytes_got = 0;
            end else if (delivered && bytes_got < 4) begin
                bytes_got++;
            end
            if (go_redirect) begin
                target = $urandom;
                if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 | (target & 32'hF);
                exp_pc = target & ~32'h3;
                bytes_got = 0;
            end
            instruction_ready = go_ready;
            redirect_valid    = go_redirect;
            redirect_address  = target;
        end

        instruction_ready = 1'b0;
        redirect_valid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
